// File: rtl/dk_sound_pkg.sv
// rtl/dk_sound_pkg.sv - shared types, channel indices and timing helpers for the sound trigger path
//
// Contents:
//   ch_state_t    : per-channel sequencer state (IDLE, ON, TAIL)
//   CH_*          : channel index of each discrete sound circuit
//   CNT_W         : width of the per-channel tick counter
//   ms_to_samples : converts a duration in ms to a count of audio ticks
package dk_sound_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    TAIL = 2'd2
  } ch_state_t;

  localparam int CH_WALK  = 0;
  localparam int CH_JUMP  = 1;
  localparam int CH_STOMP = 2;
  localparam int CH_SPARE = 3;

  localparam int CNT_W = 16;

  function automatic int ms_to_samples(input int rate_hz, input int ms);
    return (rate_hz * ms) / 1000;
  endfunction

endpackage

// File: rtl/sfx_channel_fsm.sv
// rtl/sfx_channel_fsm.sv - one sound channel: request latch, min-on / decay-tail sequencer
//
// Ports:
//   clk, I_RSTn  : clock, asynchronous active-low reset
//   i_tick       : audio sample tick (one clk wide)
//   i_wr         : CPU write strobe already decoded for this channel
//   i_data       : request level carried by the write
//   i_mute       : global mute level
//   o_sound_en   : registered enable, high while ON
//   o_ch_busy    : registered busy, high while ON or TAIL
//   o_busy_nxt   : next-state busy, lets the top register an OR across channels
module sfx_channel_fsm
  import dk_sound_pkg::*;
#(
  parameter int MIN_ON = 1920,
  parameter int TAIL_N = 4800
) (
  input  logic clk,
  input  logic I_RSTn,
  input  logic i_tick,
  input  logic i_wr,
  input  logic i_data,
  input  logic i_mute,
  output logic o_sound_en,
  output logic o_ch_busy,
  output logic o_busy_nxt
);

  localparam logic [CNT_W-1:0] MIN_ON_M1 = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] TAIL_M1   = CNT_W'(TAIL_N - 1);

  ch_state_t        r_state;
  ch_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_req;
  logic             r_strike;
  logic             r_sound_en;
  logic             r_ch_busy;

  // The sequencer only moves on a tick and looks at req/strike as they were
  // before this edge, so a write landing on a tick cycle is seen one tick later.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (i_tick) begin
      case (r_state)
        IDLE: begin
          if (r_req && !i_mute) begin
            w_state_nxt = ON;
            w_cnt_nxt   = MIN_ON_M1;
          end
        end
        ON: begin
          if (i_mute) begin
            // mute cuts the minimum on-time short but still leaves the decay tail
            w_state_nxt = TAIL;
            w_cnt_nxt   = TAIL_M1;
          end else if (r_strike) begin
            w_cnt_nxt = MIN_ON_M1;
          end else if (r_cnt == '0 && !r_req) begin
            w_state_nxt = TAIL;
            w_cnt_nxt   = TAIL_M1;
          end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        TAIL: begin
          if (r_req && !i_mute) begin
            w_state_nxt = ON;
            w_cnt_nxt   = MIN_ON_M1;
          end else if (r_cnt == '0) begin
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_req      <= 1'b0;
      r_strike   <= 1'b0;
      r_sound_en <= 1'b0;
      r_ch_busy  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sound_en <= (w_state_nxt == ON);
      r_ch_busy  <= (w_state_nxt != IDLE);
      if (i_wr) begin
        r_req <= i_data;
      end
      // a new 1-write beats the per-tick clear so a write on a tick cycle is not lost
      if (i_wr && i_data) begin
        r_strike <= 1'b1;
      end else if (i_tick) begin
        r_strike <= 1'b0;
      end
    end
  end

  assign o_sound_en = r_sound_en;
  assign o_ch_busy  = r_ch_busy;
  assign o_busy_nxt = (w_state_nxt != IDLE);

endmodule

// File: rtl/dk_sfx_trigger_ctrl.sv
// rtl/dk_sfx_trigger_ctrl.sv - CPU sound-latch writes to tick-aligned per-channel sound enables
//
// Ports:
//   clk, I_RSTn   : clock, asynchronous active-low reset
//   audio_clk_en  : one-clk audio sample tick
//   cpu_wr        : one-clk CPU write strobe
//   cpu_addr      : channel index of the write (out-of-range indices are ignored)
//   cpu_data      : request level
//   mute          : global mute, level-sensitive
//   sound_en      : per-channel enable to the discrete circuits
//   ch_busy       : per-channel busy (ON or decay tail)
//   any_busy      : OR of all channel busy flags, registered
module dk_sfx_trigger_ctrl
  import dk_sound_pkg::*;
#(
  parameter  int SAMPLE_RATE = 96000,
  parameter  int NUM_CH      = 4,
  parameter  int MIN_ON_MS   = 20,
  parameter  int TAIL_MS     = 50,
  localparam int ADDR_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              I_RSTn,
  input  logic              audio_clk_en,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_data,
  input  logic              mute,
  output logic [NUM_CH-1:0] sound_en,
  output logic [NUM_CH-1:0] ch_busy,
  output logic              any_busy
);

  localparam int MIN_ON = ms_to_samples(SAMPLE_RATE, MIN_ON_MS);
  localparam int TAIL_N = ms_to_samples(SAMPLE_RATE, TAIL_MS);

  if (MIN_ON < 1 || MIN_ON > 65535 || TAIL_N < 1 || TAIL_N > 65535 || NUM_CH < 1) begin : g_bad_params
    $error("dk_sfx_trigger_ctrl: MIN_ON/TAIL must be in 1..65535 and NUM_CH >= 1");
  end

  logic [NUM_CH-1:0] w_wr_sel;
  logic [NUM_CH-1:0] w_busy_nxt;
  logic              r_any_busy;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    // an index with no matching channel selects nothing, which drops the write
    assign w_wr_sel[gi] = cpu_wr && (cpu_addr == ADDR_W'(gi));

    sfx_channel_fsm #(
      .MIN_ON (MIN_ON),
      .TAIL_N (TAIL_N)
    ) u_ch (
      .clk        (clk),
      .I_RSTn     (I_RSTn),
      .i_tick     (audio_clk_en),
      .i_wr       (w_wr_sel[gi]),
      .i_data     (cpu_data),
      .i_mute     (mute),
      .o_sound_en (sound_en[gi]),
      .o_ch_busy  (ch_busy[gi]),
      .o_busy_nxt (w_busy_nxt[gi])
    );
  end

  // registered from next-state so it lines up with the per-channel ch_busy flops
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      r_any_busy <= 1'b0;
    end else begin
      r_any_busy <= |w_busy_nxt;
    end
  end

  assign any_busy = r_any_busy;

endmodule

// File: doc/dk_sfx_trigger_ctrl.md
# dk_sfx_trigger_ctrl

Sequencer between the CPU sound-latch writes and the discrete sound circuits (walk, jump, stomp, spare). It turns raw CPU bit writes into per-channel enables that only change on `audio_clk_en` sample boundaries. Each enable has a guaranteed minimum on-time and a busy tail that covers the analog decay. The enables drive the `*_en` inputs of the discrete circuit modules; `ch_busy` and `any_busy` feed mixer gating.

## Interface
Parameters:
- `SAMPLE_RATE`, 96000: audio tick rate in Hz.
- `NUM_CH`, 4: number of sound channels.
- `MIN_ON_MS`, 20: minimum enable time. `MIN_ON = SAMPLE_RATE*MIN_ON_MS/1000`, which is 1920 at defaults.
- `TAIL_MS`, 50: decay window. `TAIL = SAMPLE_RATE*TAIL_MS/1000`, which is 4800 at defaults.

Ports:
- Reset `I_RSTn`, asynchronous, active-low; clock `clk`.
- `audio_clk_en`, in, 1: one-clk sample tick.
- `cpu_wr`, in, 1: one-clk write strobe.
- `cpu_addr`, in, `$clog2(NUM_CH)`: channel index.
- `cpu_data`, in, 1: request level.
- `mute`, in, 1: global mute, level-sensitive.
- `sound_en`, out, `NUM_CH`: per-channel enable.
- `ch_busy`, out, `NUM_CH`: channel is not IDLE.
- `any_busy`, out, 1: OR of `ch_busy`.

## Operation
- **CPU write.** On a `cpu_wr` cycle:
  - `req[cpu_addr] <= cpu_data`.
  - If `cpu_data` is 1, also set `strike[cpu_addr]`.
  - If `cpu_addr >= NUM_CH`, the write is ignored.
  - `req` and `strike` update on any clk.
- **Per-channel FSM.** Evaluates only on `audio_clk_en` cycles and uses the pre-edge values of `req`/`strike`. `strike` is cleared on every tick. Counter `cnt` is 16 bits.
  - **IDLE**
    - If `req` and not `mute`: go to ON, `cnt <= MIN_ON-1`.
  - **ON** (`sound_en`=1)
    - If `mute`: go to TAIL, `cnt <= TAIL-1`. Mute overrides the minimum on-time.
    - Else if `strike`: `cnt <= MIN_ON-1` (retrigger).
    - Else if `cnt==0` and not `req`: go to TAIL, `cnt <= TAIL-1`.
    - Else if `cnt>0`: `cnt--`.
  - **TAIL** (`sound_en`=0)
    - If `req` and not `mute`: go to ON, `cnt <= MIN_ON-1`.
    - Else if `cnt==0`: go to IDLE.
    - Else `cnt--`.
- **Outputs.**
  - `sound_en = (state==ON)` and `ch_busy = (state!=IDLE)`, both registered.
  - `any_busy` is registered from next-state.
- **Parameter bounds.** Elaboration fails unless `1 <= MIN_ON`, `TAIL <= 65535`, and `NUM_CH >= 1`.

## Timing
- **Reset.**
  - Async reset clears all outputs to 0, `req` and `strike` to 0, states to IDLE and `cnt` to 0.
  - Reset asserted mid-ON drops `sound_en` immediately, with no tail.
- **Write latency.** A write takes effect on the first `audio_clk_en` strictly after the write cycle. A write coincident with a tick is seen on the following tick. `sound_en` changes on that tick's clk edge.
- **Minimum on-time.** A request pulse of any length gives `sound_en` high for exactly `MIN_ON` ticks.
- **Held request.** If `req` is held through tick N (last tick with `req`=1), `sound_en` falls at tick N+1 at the earliest, and never before `MIN_ON` ticks.
- **Tail.** The tail lasts exactly `TAIL` ticks of `ch_busy`=1 with `sound_en`=0.
- **Channel independence.** Channels are independent. Simultaneous ticks on all channels are handled in the same cycle.
- **Write during mute.** Writes while `mute` is high still update `req`. A channel starts when `mute` drops, if `req` is still 1.
- **Tick gap.** Outputs are stable between ticks.

## Structure
- **`dk_sound_pkg`** holds:
  - `ch_state_t` enum {IDLE, ON, TAIL};
  - `CH_WALK=0`, `CH_JUMP=1`, `CH_STOMP=2`, `CH_SPARE=3`;
  - a ms-to-samples conversion function.
- **`sfx_channel_fsm`** is a natural sub-module: state, `cnt`, `req`, `strike` for one channel.
  - The top level instantiates it `NUM_CH` times in a generate loop.
  - The top level holds the address decode and `any_busy`.

## Test plan
Use defaults and ticks every 10 clk.
1. **Reset.** Assert reset mid-stream → all outputs 0 asynchronously. After release, no output changes without writes.
2. **Short pulse.** Write ch0=1, then ch0=0 three ticks later → `sound_en[0]` high exactly 1920 ticks, `ch_busy[0]` high for 1920+4800 ticks, then IDLE.
3. **Held request.** Write ch1=1, hold 3000 ticks, then write 0 → `sound_en[1]` falls on the first tick after the clearing write (3001 ticks high), then a 4800-tick tail.
4. **Retrigger.**
   - Write ch2=1 at tick 100 of its tail → `sound_en[2]` rises on the next tick and stays ≥1920 ticks.
   - A second 1-write at ON tick 1000 extends on-time to 1000+1920.
5. **Mute.**
   - Raise `mute` during ch0 ON → `sound_en[0]`=0 on the next tick, tail of 4800.
   - Write ch3=1 while muted → no start. Drop `mute` → ch3 starts on the next tick.
6. **Simultaneous events.**
   - Write coincident with a tick → response delayed one tick.
   - Write with `cpu_addr`=3 when `NUM_CH`=3 → ignored.
   - Writes to ch0 and ch1 in consecutive clks → both enable on the same tick.
